cmem_arbiter: RTL and testbench

- Shares the single layer-result memory port (cwr/crd/caddr_wr/caddr_rd/cdata_wr/csel) between two requesters: layer-0 conv writer (port A) and layer-1/2 pool/flatten engine (port B, reads and writes).
- Round-robin grant, optional burst lock, registered memory-side outputs, read-data return routed to the issuing requester.
- Sits between the layer engines and the top-level memory pins, replacing direct wiring of layer outputs to pins.

---
 rtl/cmem_pkg.sv | 21 ++
 rtl/cmem_rr_pick.sv | 31 +++
 rtl/cmem_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_cmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmem_pkg.sv
// Shared definitions for the layer-result memory arbiter: default widths,
// arbiter state encoding, port identifiers and a saturating counter helper.
package cmem_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cmem_rr_pick.sv
// Combinational 2-way round-robin picker. A locked owner state restricts the
// grant to that port; otherwise ties go to the port that did not win last.
module cmem_rr_pick
    import cmem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_winner,
    input  arb_state_e i_state,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_state)
            OWN_A: o_gnt[PORT_A] = i_req[PORT_A];
            OWN_B: o_gnt[PORT_B] = i_req[PORT_B];
            default: begin
                if (i_req == 2'b11) begin
                    if (i_last_winner == PORT_B) begin
                        o_gnt[PORT_A] = 1'b1;
                    end else begin
                        o_gnt[PORT_B] = 1'b1;
                    end
                end else begin
                    o_gnt = i_req;
                end
            end
        endcase
    end

endmodule

// File: rtl/cmem_arbiter.sv
// Round-robin arbiter sharing the layer-result memory port between the conv
// writer (A) and pool/flatten engine (B). Define CMEM_ARB_STATS_EN for beat/conflict counters.
module cmem_arbiter
    import cmem_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [2:0]    a_sel,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          a_lock,
    output logic          a_gnt,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [2:0]    b_sel,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_lock,
    output logic          b_gnt,
    output logic          b_rvalid,
`ifdef CMEM_ARB_STATS_EN
    output logic [15:0]   a_beats,
    output logic [15:0]   b_beats,
    output logic [15:0]   conflict_cnt,
`endif
    output logic [DW-1:0] rdata,
    output logic          cwr,
    output logic          crd,
    output logic [2:0]    csel,
    output logic [AW-1:0] caddr_wr,
    output logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_wr,
    input  logic [DW-1:0] cdata_rd,
    output logic          idle
);

    localparam int         TAG_DEPTH   = 2;
    localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);

    logic [1:0]    w_req;
    logic [1:0]    w_pick_gnt;
    logic [1:0]    w_gnt;
    logic          w_acc;
    logic          w_acc_port;
    logic          w_we;
    logic          w_lock;
    logic [2:0]    w_sel;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    arb_state_e    r_state, w_state_next;
    logic          r_last_winner, w_last_winner_next;
    logic [7:0]    r_burst_cnt, w_burst_next;
    logic [8:0]    w_burst_inc;

    logic          r_cwr, r_crd;
    logic [2:0]    r_csel;
    logic [AW-1:0] r_caddr_wr, r_caddr_rd;
    logic [DW-1:0] r_cdata_wr, r_rdata;
    logic          r_a_rvalid, r_b_rvalid;
    logic          r_tag_vld [TAG_DEPTH];
    logic          r_tag_own [TAG_DEPTH];
    logic          w_tag_busy;

    assign w_req = {b_req, a_req};

    cmem_rr_pick u_pick (
        .i_req         (w_req),
        .i_last_winner (r_last_winner),
        .i_state       (r_state),
        .o_gnt         (w_pick_gnt)
    );

    // No beat may be accepted while reset is being sampled.
    assign w_gnt      = reset ? 2'b00 : w_pick_gnt;
    assign w_acc      = |w_gnt;
    assign w_acc_port = w_gnt[PORT_B];

    assign w_we    = w_acc_port ? b_we    : a_we;
    assign w_lock  = w_acc_port ? b_lock  : a_lock;
    assign w_sel   = w_acc_port ? b_sel   : a_sel;
    assign w_addr  = w_acc_port ? b_addr  : a_addr;
    assign w_wdata = w_acc_port ? b_wdata : a_wdata;

    assign w_burst_inc = {1'b0, r_burst_cnt} + 9'd1;

    always_comb begin
        w_state_next       = r_state;
        w_last_winner_next = r_last_winner;
        w_burst_next       = r_burst_cnt;
        if (w_acc) begin
            w_last_winner_next = w_acc_port;
        end
        case (r_state)
            IDLE: begin
                // The opening beat of a locked run counts toward MAX_BURST.
                if (w_acc && w_lock && (MAX_BURST > 1)) begin
                    w_state_next = w_acc_port ? OWN_B : OWN_A;
                    w_burst_next = 8'd1;
                end
            end
            OWN_A, OWN_B: begin
                if (!w_acc || !w_lock || (w_burst_inc >= BURST_LIMIT)) begin
                    w_state_next = IDLE;
                    w_burst_next = 8'd0;
                end else begin
                    w_burst_next = w_burst_inc[7:0];
                end
            end
            default: begin
                w_state_next = IDLE;
                w_burst_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last_winner <= PORT_B;
            r_burst_cnt   <= 8'd0;
        end else begin
            r_state       <= w_state_next;
            r_last_winner <= w_last_winner_next;
            r_burst_cnt   <= w_burst_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cwr      <= 1'b0;
            r_crd      <= 1'b0;
            r_csel     <= 3'd0;
            r_caddr_wr <= '0;
            r_caddr_rd <= '0;
            r_cdata_wr <= '0;
        end else begin
            r_cwr <= w_acc & w_we;
            r_crd <= w_acc & ~w_we;
            if (w_acc) begin
                r_csel <= w_sel;
                if (w_we) begin
                    r_caddr_wr <= w_addr;
                    r_cdata_wr <= w_wdata;
                end else begin
                    r_caddr_rd <= w_addr;
                end
            end
        end
    end

    // Owner tags follow each read through the strobe and memory-latency cycles.
    generate
        for (genvar gi = 0; gi < TAG_DEPTH; gi++) begin : g_tag
            logic w_vld_in;
            logic w_own_in;
            if (gi == 0) begin : g_head
                assign w_vld_in = w_acc & ~w_we;
                assign w_own_in = w_acc_port;
            end else begin : g_body
                assign w_vld_in = r_tag_vld[gi-1];
                assign w_own_in = r_tag_own[gi-1];
            end
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_tag_vld[gi] <= 1'b0;
                    r_tag_own[gi] <= PORT_A;
                end else begin
                    r_tag_vld[gi] <= w_vld_in;
                    r_tag_own[gi] <= w_own_in;
                end
            end
        end
    endgenerate

    always_comb begin
        w_tag_busy = 1'b0;
        for (int i = 0; i < TAG_DEPTH; i++) begin
            w_tag_busy = w_tag_busy | r_tag_vld[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_a_rvalid <= r_tag_vld[TAG_DEPTH-1] & (r_tag_own[TAG_DEPTH-1] == PORT_A);
            r_b_rvalid <= r_tag_vld[TAG_DEPTH-1] & (r_tag_own[TAG_DEPTH-1] == PORT_B);
            if (r_tag_vld[TAG_DEPTH-1]) begin
                r_rdata <= cdata_rd;
            end
        end
    end

`ifdef CMEM_ARB_STATS_EN
    logic [15:0] r_a_beats, r_b_beats, r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_beats      <= 16'd0;
            r_b_beats      <= 16'd0;
            r_conflict_cnt <= 16'd0;
        end else begin
            if (w_gnt[PORT_A]) r_a_beats <= sat_inc16(r_a_beats);
            if (w_gnt[PORT_B]) r_b_beats <= sat_inc16(r_b_beats);
            if (a_req & b_req) r_conflict_cnt <= sat_inc16(r_conflict_cnt);
        end
    end

    assign a_beats      = r_a_beats;
    assign b_beats      = r_b_beats;
    assign conflict_cnt = r_conflict_cnt;
`endif

    assign a_gnt    = w_gnt[PORT_A];
    assign b_gnt    = w_gnt[PORT_B];
    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign rdata    = r_rdata;
    assign cwr      = r_cwr;
    assign crd      = r_crd;
    assign csel     = r_csel;
    assign caddr_wr = r_caddr_wr;
    assign caddr_rd = r_caddr_rd;
    assign cdata_wr = r_cdata_wr;
    assign idle     = ~reset & ~a_req & ~b_req & ~r_cwr & ~r_crd & ~w_tag_busy;

endmodule

// File: tb/tb_cmem_arbiter.sv
// Randomized scoreboard bench for cmem_arbiter: a reference model predicts grants,
// memory beats and read returns; a monitor pops expectations as the DUT produces outputs.
module tb_cmem_arbiter;

    localparam int AW        = 12;
    localparam int DW        = 20;
    localparam int MAX_BURST = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [2:0]    a_sel, b_sel;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] rdata, cdata_wr;
    logic [DW-1:0] cdata_rd = '0;
    logic          cwr, crd, idle;
    logic [2:0]    csel;
    logic [AW-1:0] caddr_wr, caddr_rd;
`ifdef CMEM_ARB_STATS_EN
    logic [15:0]   a_beats, b_beats, conflict_cnt;
`endif

    // requester-side state, index 0 = port A, 1 = port B
    logic          rq [2];
    logic          we_v [2];
    logic          lk [2];
    logic [2:0]    sel_v [2];
    logic [AW-1:0] addr_v [2];
    logic [DW-1:0] wd_v [2];
    bit            acc [2];
    int            req_pct [2];
    int            we_pct [2];
    int            lock_pct [2];

    assign a_req = rq[0];   assign b_req = rq[1];
    assign a_we = we_v[0];  assign b_we = we_v[1];
    assign a_lock = lk[0];  assign b_lock = lk[1];
    assign a_sel = sel_v[0]; assign b_sel = sel_v[1];
    assign a_addr = addr_v[0]; assign b_addr = addr_v[1];
    assign a_wdata = wd_v[0]; assign b_wdata = wd_v[1];

    cmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_sel(a_sel), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_lock(a_lock), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_sel(b_sel), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
`ifdef CMEM_ARB_STATS_EN
        .a_beats(a_beats), .b_beats(b_beats), .conflict_cnt(conflict_cnt),
`endif
        .rdata(rdata), .cwr(cwr), .crd(crd), .csel(csel),
        .caddr_wr(caddr_wr), .caddr_rd(caddr_rd), .cdata_wr(cdata_wr),
        .cdata_rd(cdata_rd), .idle(idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return {a[7:0], a} ^ 20'h5A3C1;
    endfunction

    // Memory: data for the address strobed with crd appears in the following cycle.
    logic          pend_v = 1'b0;
    logic [AW-1:0] pend_a = '0;
    always @(negedge clk) begin
        pend_v = crd;
        pend_a = caddr_rd;
    end
    always @(posedge clk) begin
        #1;
        cdata_rd = pend_v ? rom(pend_a) : DW'($urandom);
    end

    typedef struct {
        logic          we;
        logic [2:0]    sel;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        int            cyc;
    } mem_exp_t;
    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            cyc;
    } rd_exp_t;
    mem_exp_t mem_q [$];
    rd_exp_t  rd_q [$];

    // Reference model: who owns the port, length of the current locked run, last winner.
    int            own = -1;
    int            run = 0;
    int            last = 1;
    int            m_w;
    logic          exp_idle;
    logic          wr_d1 = 1'b0, rd_d1 = 1'b0, rd_d2 = 1'b0;
    logic [2:0]    h_sel = '0;
    logic [AW-1:0] h_wa = '0, h_ra = '0;
    logic [DW-1:0] h_wd = '0;

    always @(negedge clk) begin
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        if (reset) begin
            chk("gnt_in_reset", {62'd0, a_gnt, b_gnt}, 64'd0);
            own = -1; run = 0; last = 1;
            wr_d1 = 1'b0; rd_d1 = 1'b0; rd_d2 = 1'b0;
            h_sel = '0; h_wa = '0; h_wd = '0; h_ra = '0;
        end else begin
            m_w = -1;
            if (own >= 0) begin
                if (rq[own]) m_w = own;
            end else if (rq[0] && rq[1]) begin
                m_w = 1 - last;
            end else if (rq[0]) begin
                m_w = 0;
            end else if (rq[1]) begin
                m_w = 1;
            end
            exp_idle = !rq[0] && !rq[1] && !wr_d1 && !rd_d1 && !rd_d2;
            chk("gnt", {62'd0, a_gnt, b_gnt}, {62'd0, m_w == 0, m_w == 1});
            chk("idle", {63'd0, idle}, {63'd0, exp_idle});
            wr_d1 = 1'b0;
            rd_d2 = rd_d1;
            rd_d1 = 1'b0;
            if (m_w >= 0) begin
                acc[m_w] = 1'b1;
                h_sel = sel_v[m_w];
                if (we_v[m_w]) begin
                    h_wa = addr_v[m_w]; h_wd = wd_v[m_w]; wr_d1 = 1'b1;
                end else begin
                    h_ra = addr_v[m_w]; rd_d1 = 1'b1;
                    rd_q.push_back('{port: m_w[0], data: rom(addr_v[m_w]), cyc: cyc + 3});
                end
                mem_q.push_back('{we: we_v[m_w], sel: h_sel, wa: h_wa, wd: h_wd, ra: h_ra, cyc: cyc + 1});
                $display("beat cyc=%0d port=%s %s sel=%0d addr=%h wdata=%h lock=%0b",
                         cyc, (m_w == 0) ? "A" : "B", we_v[m_w] ? "WR" : "RD",
                         sel_v[m_w], addr_v[m_w], wd_v[m_w], lk[m_w]);
                last = m_w;
                if (own < 0) begin
                    if (lk[m_w] && MAX_BURST > 1) begin
                        own = m_w;
                        run = 1;
                    end
                end else begin
                    run++;
                    if (!lk[m_w] || run >= MAX_BURST) own = -1;
                end
            end else if (own >= 0) begin
                own = -1;
            end
        end
    end

    // Monitor: compares DUT memory beats and read returns against queued expectations.
    mem_exp_t me;
    rd_exp_t  re;
    always @(negedge clk) begin
        while (mem_q.size() > 0 && mem_q[0].cyc < cyc) begin
            me = mem_q.pop_front();
            chk("mem_missing", 64'(cyc), 64'(me.cyc));
        end
        while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            re = rd_q.pop_front();
            chk("rvalid_missing", 64'(cyc), 64'(re.cyc));
        end
        if (cwr || crd) begin
            if (mem_q.size() == 0) begin
                chk("mem_spurious", {62'd0, cwr, crd}, 64'd0);
            end else begin
                me = mem_q.pop_front();
                chk("mem_cycle", 64'(cyc), 64'(me.cyc));
                chk("mem_beat", {15'd0, cwr, crd, csel, caddr_wr, cdata_wr, caddr_rd},
                    {15'd0, me.we, !me.we, me.sel, me.wa, me.wd, me.ra});
            end
        end
        if (a_rvalid || b_rvalid) begin
            if (rd_q.size() == 0) begin
                chk("rvalid_spurious", {62'd0, a_rvalid, b_rvalid}, 64'd0);
            end else begin
                re = rd_q.pop_front();
                chk("rd_cycle", 64'(cyc), 64'(re.cyc));
                chk("rd_port", {62'd0, a_rvalid, b_rvalid}, {62'd0, re.port == 1'b0, re.port == 1'b1});
                chk("rd_data", {44'd0, rdata}, {44'd0, re.data});
            end
        end
        if (reset) begin
            mem_q.delete();
            rd_q.delete();
        end
    end

    task automatic new_req(input int p);
        rq[p]     = (int'($urandom_range(99)) < req_pct[p]);
        we_v[p]   = (int'($urandom_range(99)) < we_pct[p]);
        lk[p]     = (int'($urandom_range(99)) < lock_pct[p]);
        sel_v[p]  = 3'($urandom_range(7));
        addr_v[p] = AW'($urandom);
        wd_v[p]   = DW'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (acc[p] || !rq[p]) new_req(p);
        end
    endtask

    task automatic set_pct(input int ar, input int aw, input int al,
                           input int br, input int bw, input int bl);
        req_pct[0] = ar; we_pct[0] = aw; lock_pct[0] = al;
        req_pct[1] = br; we_pct[1] = bw; lock_pct[1] = bl;
    endtask

    task automatic check_outputs_zero(input string nm);
        chk(nm, {13'd0, cwr, crd, csel, a_rvalid, b_rvalid, caddr_wr, caddr_rd, cdata_wr}, 64'd0);
        chk({nm, "_rdata"}, {44'd0, rdata}, 64'd0);
        chk({nm, "_idle"}, {63'd0, idle}, 64'd1);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; we_v[p] = 1'b0; lk[p] = 1'b0;
            sel_v[p] = '0; addr_v[p] = '0; wd_v[p] = '0;
        end
        set_pct(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_state");
        tick();

        // single write from A
        rq[0] = 1'b1; we_v[0] = 1'b1; sel_v[0] = 3'd1;
        addr_v[0] = 12'h005; wd_v[0] = 20'h0ABCD; lk[0] = 1'b0;
        repeat (3) tick();

        set_pct(100, 50, 0, 100, 50, 0);    // contention, no lock
        repeat (16) tick();
        set_pct(100, 100, 100, 100, 50, 0); // A locked bursts against B
        repeat (40) tick();
        set_pct(0, 0, 0, 100, 0, 0);        // B back-to-back reads
        repeat (12) tick();
        set_pct(100, 0, 0, 100, 100, 0);    // A reads interleaved with B writes
        repeat (12) tick();

        repeat (15) begin
            set_pct($urandom_range(100), $urandom_range(100), $urandom_range(100),
                    $urandom_range(100), $urandom_range(100), $urandom_range(100));
            repeat (200) tick();
        end

        // reset in the middle of a read burst
        set_pct(0, 0, 0, 0, 0, 0);
        repeat (12) tick();
        set_pct(0, 0, 0, 100, 0, 0);
        repeat (3) tick();
        reset = 1'b1;
        rq[0] = 1'b0; rq[1] = 1'b0;
        set_pct(0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_read_reset");
        repeat (5) begin
            tick();
            @(negedge clk);
            chk("no_rvalid_after_reset", {62'd0, a_rvalid, b_rvalid}, 64'd0);
        end

        repeat (12) tick();
        @(negedge clk);
        chk("drain", 64'(mem_q.size() + rd_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
